// File: rtl/word_register.sv
//==============================================================================
// Module      : word_register
// Description : Clocked WIDTH-bit storage register built from identical
//               1-bit hold/load cells with synchronous reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

// One storage bit: hold/load mux in front of a rising-edge flop whose
// synchronous reset clears or presets it according to RESET_BIT.
module word_register_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d,
    output logic q
);

    logic r_q;
    logic w_next;

    assign w_next = load ? d : r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_BIT;
        end else begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

module word_register #(
    parameter int              WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    // Each output bit sees only its own data bit plus the shared controls,
    // so all bits update together on the same edge.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        word_register_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .d    (d_in[i]),
            .q    (d_out[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_word_register.sv
//==============================================================================
// Module      : tb_word_register
// Description : Directed self-checking bench for word_register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_word_register;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic [15:0] d_out_rv;
    logic [0:0]  d_in_w1;
    logic [0:0]  d_out_w1;
    logic [31:0] d_in_w32;
    logic [31:0] d_out_w32;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    word_register u_dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .d_in  (d_in),
        .d_out (d_out)
    );

    word_register #(.WIDTH(16), .RESET_VALUE(16'h8001)) u_dut_rv (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .d_in  (d_in),
        .d_out (d_out_rv)
    );

    word_register #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut_w1 (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .d_in  (d_in_w1),
        .d_out (d_out_w1)
    );

    word_register #(.WIDTH(32), .RESET_VALUE(32'h0)) u_dut_w32 (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .d_in  (d_in_w32),
        .d_out (d_out_w32)
    );

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0;
        d_in = 16'h5A5A; d_in_w1 = 1'b1; d_in_w32 = 32'h1234_5678;
        tick();
        n_checks++;
        if (d_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_main: got %h expected %h", d_out, 16'h0000);
        end
        n_checks++;
        if (d_out_rv !== 16'h8001) begin
            n_fail++; $display("FAIL reset_rv: got %h expected %h", d_out_rv, 16'h8001);
        end
        n_checks++;
        if (d_out_w32 !== 32'h0) begin
            n_fail++; $display("FAIL reset_w32: got %h expected %h", d_out_w32, 32'h0);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_and_falling_edge();
        load = 1'b1; d_in = 16'b1001001110011010;
        tick();
        n_checks++;
        if (d_out !== 16'b1001001110011010) begin
            n_fail++; $display("FAIL load_first: got %h expected %h", d_out, 16'h939A);
        end
        @(negedge clk);
        d_in = 16'hFFFF;
        #2;
        n_checks++;
        if (d_out !== 16'h939A) begin
            n_fail++; $display("FAIL clk_low_hold: got %h expected %h", d_out, 16'h939A);
        end
        d_in = 16'b1100111011011000;
        tick();
        n_checks++;
        if (d_out !== 16'hCED8) begin
            n_fail++; $display("FAIL load_second: got %h expected %h", d_out, 16'hCED8);
        end
    endtask

    task automatic test_hold();
        load = 1'b1; d_in = 16'hBEEF;
        tick();
        load = 1'b0; d_in = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (d_out !== 16'hBEEF) begin
                n_fail++; $display("FAIL hold_%0d: got %h expected %h", i, d_out, 16'hBEEF);
            end
        end
        load = 1'b1;
        tick();
        n_checks++;
        if (d_out !== 16'h1234) begin
            n_fail++; $display("FAIL hold_release: got %h expected %h", d_out, 16'h1234);
        end
    endtask

    task automatic test_sync_reset();
        load = 1'b1; d_in = 16'hA5A5;
        tick();
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (d_out !== 16'hA5A5) begin
            n_fail++; $display("FAIL rst_between_edges: got %h expected %h", d_out, 16'hA5A5);
        end
        tick();
        n_checks++;
        if (d_out !== 16'h0000) begin
            n_fail++; $display("FAIL rst_at_edge: got %h expected %h", d_out, 16'h0000);
        end
        rst = 1'b0; load = 1'b1; d_in = 16'h0001;
        tick();
        n_checks++;
        if (d_out !== 16'h0001) begin
            n_fail++; $display("FAIL rst_resume: got %h expected %h", d_out, 16'h0001);
        end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; load = 1'b1; d_in = 16'hFFFF;
        tick();
        n_checks++;
        if (d_out !== 16'h0000) begin
            n_fail++; $display("FAIL prio_main: got %h expected %h", d_out, 16'h0000);
        end
        n_checks++;
        if (d_out_rv !== 16'h8001) begin
            n_fail++; $display("FAIL prio_rv: got %h expected %h", d_out_rv, 16'h8001);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (d_out_rv !== 16'hFFFF) begin
            n_fail++; $display("FAIL rv_load: got %h expected %h", d_out_rv, 16'hFFFF);
        end
    endtask

    task automatic test_walking();
        logic [15:0] pat;
        load = 1'b1; rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pat  = 16'h0001 << i;
            d_in = pat;
            tick();
            n_checks++;
            if (d_out !== pat) begin
                n_fail++; $display("FAIL walk1_%0d: got %h expected %h", i, d_out, pat);
            end
        end
        for (int i = 0; i < 16; i++) begin
            pat  = ~(16'h0001 << i);
            d_in = pat;
            tick();
            n_checks++;
            if (d_out !== pat) begin
                n_fail++; $display("FAIL walk0_%0d: got %h expected %h", i, d_out, pat);
            end
        end
    endtask

    task automatic test_width();
        rst = 1'b0; load = 1'b1; d_in_w1 = 1'b1; d_in_w32 = 32'hDEADBEEF;
        tick();
        n_checks++;
        if (d_out_w1 !== 1'b1) begin
            n_fail++; $display("FAIL w1_load: got %b expected %b", d_out_w1, 1'b1);
        end
        n_checks++;
        if (d_out_w32 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL w32_load: got %h expected %h", d_out_w32, 32'hDEADBEEF);
        end
        load = 1'b0; d_in_w1 = 1'b0;
        tick();
        n_checks++;
        if (d_out_w1 !== 1'b1) begin
            n_fail++; $display("FAIL w1_hold: got %b expected %b", d_out_w1, 1'b1);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (d_out_w1 !== 1'b0) begin
            n_fail++; $display("FAIL w1_reset: got %b expected %b", d_out_w1, 1'b0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; d_in = '0; d_in_w1 = '0; d_in_w32 = '0;
        #1;
        test_reset();
        test_load_and_falling_edge();
        test_hold();
        test_sync_reset();
        test_reset_priority();
        test_walking();
        test_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
